// File: rtl/mp_mul_seq_pkg.sv
// Shared types and constants for the multi-cycle 32x32 multiply sequencer.
// State encodings, op-field bit positions and pass bookkeeping.
package mp_mul_seq_pkg;

  localparam int MUL_PASSES = 4;
  localparam int OP_HI      = 1;
  localparam int OP_SGN     = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Pass index: bit1 selects the high half of a, bit0 the high half of b.
  typedef logic [$clog2(MUL_PASSES)-1:0] pass_t;

endpackage

// File: rtl/mp_booth16.sv
// 16x16 radix-4 Booth multiplier on 17-bit two's-complement operands, combinational.
// The result is taken mod 2^32; every pass product fits that range in its own signedness.
module mp_booth16 (
  input  logic        en,
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [31:0] p
);

  logic [31:0] ax;
  logic [18:0] bx;
  logic [31:0] pp;
  logic [31:0] sum;

  assign ax = {{15{a[16]}}, a};
  assign bx = {b[16], b, 1'b0};

  always_comb begin
    sum = '0;
    pp  = '0;
    for (int i = 0; i < 9; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp = ax;
        3'b011:         pp = ax << 1;
        3'b100:         pp = -(ax << 1);
        3'b101, 3'b110: pp = -ax;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2 * i));
    end
  end

  assign p = en ? sum : '0;

endmodule

// File: rtl/mp_mul_pass.sv
// Per-pass operand-half selection and sign-extend/shift of the partial product.
// Purely combinational; outside P0..P3 the multiplier operands and addend are zero.
import mp_mul_seq_pkg::*;

module mp_mul_pass (
  input  state_t      state,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  input  logic [31:0] partial,
  output logic        mul_en,
  output logic [16:0] mul_a,
  output logic [16:0] mul_b,
  output logic [63:0] addend
);

  pass_t       pass;
  logic        a_hi;
  logic        b_hi;
  logic        psgn;
  logic [5:0]  shamt;
  logic [63:0] ext;
  logic [15:0] a_half;
  logic [15:0] b_half;

  assign mul_en = (state == S_P0) || (state == S_P1) || (state == S_P2) || (state == S_P3);
  assign pass   = pass_t'(state - S_P0);
  assign a_hi   = pass[1];
  assign b_hi   = pass[0];
  assign a_half = a_hi ? a[31:16] : a[15:0];
  assign b_half = b_hi ? b[31:16] : b[15:0];

  // Only a high half of a signed op carries a sign; low halves are always magnitudes.
  assign mul_a = mul_en ? {sgn & a_hi & a_half[15], a_half} : '0;
  assign mul_b = mul_en ? {sgn & b_hi & b_half[15], b_half} : '0;

  assign psgn   = sgn & (a_hi | b_hi);
  assign shamt  = {a_hi & b_hi, a_hi ^ b_hi, 4'b0000};
  assign ext    = psgn ? {{32{partial[31]}}, partial} : {32'b0, partial};
  assign addend = mul_en ? (ext << shamt) : '0;

endmodule

// File: rtl/mp_mul_seq.sv
// Two-lane round-robin 32x32 multiply sequencer over one shared 16x16 Booth multiplier.
// Response 5 cycles after grant (4 for FAST_LO low-word ops); result held until rsp_ready.
import mp_mul_seq_pkg::*;

module mp_mul_seq #(
  parameter bit FAST_LO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data
);

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic        id_q;
  logic        rr;
  logic [63:0] acc;
  logic [1:0]  grant;

  logic        mul_en;
  logic [16:0] mul_a;
  logic [16:0] mul_b;
  logic [31:0] partial;
  logic [63:0] addend;

  always_comb begin
    grant = 2'b00;
    if (state == S_IDLE && !flush) begin
      if (req_valid[0] && (!req_valid[1] || !rr)) grant = 2'b01;
      else if (req_valid[1])                      grant = 2'b10;
    end
  end

  mp_mul_pass u_pass (
    .state   (state),
    .a       (a_q),
    .b       (b_q),
    .sgn     (op_q[OP_SGN]),
    .partial (partial),
    .mul_en  (mul_en),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .addend  (addend)
  );

  mp_booth16 u_mul (
    .en (mul_en),
    .a  (mul_a),
    .b  (mul_b),
    .p  (partial)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      id_q  <= 1'b0;
      rr    <= 1'b0;
      acc   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            a_q   <= grant[1] ? req_a1  : req_a0;
            b_q   <= grant[1] ? req_b1  : req_b0;
            op_q  <= grant[1] ? req_op1 : req_op0;
            id_q  <= grant[1];
            rr    <= ~grant[1];
            acc   <= '0;
            state <= S_P0;
          end
        end
        S_P0: begin
          acc   <= acc + addend;
          state <= S_P1;
        end
        S_P1: begin
          acc   <= acc + addend;
          state <= S_P2;
        end
        S_P2: begin
          acc   <= acc + addend;
          // aH*bH only reaches bits 63:32, so a low-word op can stop here.
          state <= (FAST_LO && !op_q[OP_HI]) ? S_DONE : S_P3;
        end
        S_P3: begin
          acc   <= acc + addend;
          state <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state == S_DONE);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_valid ? (op_q[OP_HI] ? acc[63:32] : acc[31:0]) : 32'h0;

endmodule

// File: tb/tb_mp_mul_seq.sv
// Directed self-checking bench for mp_mul_seq: arbitration, products, latency, backpressure, flush and reset.
module tb_mp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_op0, req_op1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;

  logic [1:0]  req_valid_s;
  logic [1:0]  req_ready_s;
  logic        rsp_valid_s;
  logic        rsp_ready_s;
  logic        rsp_id_s;
  logic [31:0] rsp_data_s;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mp_mul_seq #(.FAST_LO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  mp_mul_seq #(.FAST_LO(1'b0)) dut_slow (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid_s), .req_ready(req_ready_s),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready_s), .rsp_id(rsp_id_s), .rsp_data(rsp_data_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the grant edge; returns cycles from grant to rsp_valid.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_data, input int exp_lat);
    if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; end
    else    begin req_a0 = a; req_b0 = b; req_op0 = op; end
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    check({tag, "_gnt"}, 64'(req_ready), 64'(req_valid));
    tick();
    req_valid = 2'b00;
    req_a0 = 32'hDEADBEEF; req_b0 = 32'h12345678; req_op0 = ~op;
    req_a1 = 32'hCAFEF00D; req_b1 = 32'h87654321; req_op1 = ~op;
    wait_rsp(tag, exp_lat);
    check({tag, "_data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    tick();
    check({tag, "_done"}, 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req_valid_s = 2'b00; rsp_ready_s = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id",    64'(rsp_id),    64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    rst_n = 1'b1;
    tick();

    // Both lanes held valid: 0,1,0,1 starting from rr=0.
    req_a0 = 32'd2; req_b0 = 32'd3; req_op0 = 2'b00;
    req_a1 = 32'd5; req_b1 = 32'd7; req_op1 = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt", 64'(req_ready), (k % 2) ? 64'h2 : 64'h1);
      tick();
      wait_rsp("rr", 4);
      check("rr_done_nogrant", 64'(req_ready), 64'(0));
      check("rr_id",   64'(rsp_id),   64'(k % 2));
      check("rr_data", 64'(rsp_data), (k % 2) ? 64'd35 : 64'd6);
      tick();
      if (k == 3) req_valid = 2'b00;
    end

    // Backpressure: lane 1 alone, then both lanes valid while the result is held.
    req_a1 = 32'h00030002; req_b1 = 32'h00050004; req_op1 = 2'b10;
    req_valid = 2'b10;
    #1;
    check("bp_gnt", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    wait_rsp("bp", 5);
    for (int k = 0; k < 7; k++) begin
      check("bp_valid", 64'(rsp_valid), 64'(1));
      check("bp_data",  64'(rsp_data),  64'h0000000F);
      check("bp_id",    64'(rsp_id),    64'(1));
      check("bp_nogrant", 64'(req_ready), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_accept_nogrant", 64'(req_ready), 64'(0));
    tick();
    check("bp_next_gnt", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    wait_rsp("bp_next", 4);
    check("bp_next_data", 64'(rsp_data), 64'd6);
    tick();

    run_op("hi_u_2p32",  1'b0, 32'h00010000, 32'h00010000, 2'b10, 32'h00000001, 5);
    run_op("hi_u_ones",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFE, 5);
    run_op("hi_s_ones",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000, 5);
    run_op("lo_u_ones",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001, 4);
    run_op("lo_s_ones",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h00000001, 4);
    run_op("hi_s_m2x3",  1'b0, 32'hFFFFFFFE, 32'h00000003, 2'b11, 32'hFFFFFFFF, 5);
    run_op("lo_s_m2x3",  1'b0, 32'hFFFFFFFE, 32'h00000003, 2'b01, 32'hFFFFFFFA, 4);
    run_op("lo_u_m2x3",  1'b0, 32'hFFFFFFFE, 32'h00000003, 2'b00, 32'hFFFFFFFA, 4);
    run_op("hi_u_m2x3",  1'b0, 32'hFFFFFFFE, 32'h00000003, 2'b10, 32'h00000002, 5);
    run_op("hi_s_min2",  1'b1, 32'h80000000, 32'h80000000, 2'b11, 32'h40000000, 5);
    run_op("hi_s_minx1", 1'b1, 32'h80000000, 32'h00000001, 2'b11, 32'hFFFFFFFF, 5);
    run_op("hi_u_minx1", 1'b1, 32'h80000000, 32'h00000001, 2'b10, 32'h00000000, 5);
    run_op("lo_s_minx1", 1'b0, 32'h80000000, 32'h00000001, 2'b01, 32'h80000000, 4);
    run_op("lo_u_mixed", 1'b0, 32'h00030002, 32'h00050004, 2'b00, 32'h00160008, 4);

    // FAST_LO=0 build runs all four passes for a low-word op.
    req_a0 = 32'hFFFFFFFE; req_b0 = 32'h00000003; req_op0 = 2'b01;
    req_valid_s = 2'b01;
    #1;
    check("slow_gnt", 64'(req_ready_s), 64'h1);
    tick();
    req_valid_s = 2'b00;
    begin
      int n = 1;
      while (!rsp_valid_s && n < 20) begin
        tick();
        n++;
      end
      check("slow_lat", 64'(n), 64'(5));
    end
    check("slow_data", 64'(rsp_data_s), 64'hFFFFFFFA);
    tick();

    // Flush during P2: op dropped, no grant while flush is high.
    req_a0 = 32'h00010000; req_b0 = 32'h00010000; req_op0 = 2'b10;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    flush = 1'b1;
    req_valid = 2'b01;
    tick();
    check("flush_idle_nogrant", 64'(req_ready), 64'(0));
    check("flush_rsp_valid", 64'(rsp_valid), 64'(0));
    tick();
    flush = 1'b0;
    req_valid = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_rsp", 64'(seen), 64'(0));

    // Async reset during P1 of the next op.
    req_a1 = 32'hFFFFFFFF; req_b1 = 32'hFFFFFFFF; req_op1 = 2'b10;
    req_valid = 2'b10;
    #1;
    check("rstab_gnt", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    #1;
    check("rstab_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstab_rsp_id",    64'(rsp_id),    64'(0));
    check("rstab_rsp_data",  64'(rsp_data),  64'(0));
    check("rstab_req_ready", 64'(req_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("rstab_no_rsp", 64'(seen), 64'(0));
    run_op("post_rst", 1'b1, 32'h00030002, 32'h00050004, 2'b10, 32'h0000000F, 5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mp_mul_seq.md
# mp_mul_seq

Multi-cycle 32×32 multiply sequencer for the sodium MP calc stage. It arbitrates between two requesters (the two issue lanes) and time-shares one 16×16 Booth multiplier instance across 3–4 partial-product passes. It accumulates the passes in a 64-bit register and returns the low or high 32-bit word of the product over a tagged valid/ready response port.

## Interface
- `FAST_LO`, default 1: low-word ops skip the aH·bH pass (3 passes instead of 4).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous abort of any in-flight op.
- `req_valid` in 2: per-requester request valid.
- `req_ready` out 2: per-requester grant/accept.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands.
- `req_op0`, `req_op1` in 2: bit1 is HI (return upper word), bit0 is SGN (both operands signed).
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 1: requester that issued the op.
- `rsp_data` out 32: selected product word.

## Operation
- FSM states: IDLE, P0, P1, P2, P3, DONE.
- IDLE: the arbiter grants one requester (`req_ready` one-hot, same cycle as `req_valid`, only in IDLE). The block latches operands, op and id, clears the accumulator and goes to P0.
- Arbitration is round-robin. Pointer `rr` resets to 0. When both requesters are valid, the one equal to `rr` wins. After any grant, `rr` becomes the complement of the granted id. A lone requester always wins.
- Passes (L/H = 16-bit halves):
  - P0: aL·bL, unsigned×unsigned, added at shift 0.
  - P1: aL·bH, b signed iff SGN, added at shift 16.
  - P2: aH·bL, a signed iff SGN, added at shift 16.
  - P3: aH·bH, signed×signed iff SGN, added at shift 32.
- Each 32-bit partial is sign-extended to 64 bits iff it carries a signed operand, shifted, then added mod 2^64 into `acc`.
- Transitions: P0→P1→P2. From P2, go to DONE when `FAST_LO` && !HI; otherwise go to P3. P3→DONE.
- DONE: `rsp_valid`=1. `rsp_data` = `acc[63:32]` if HI, else `acc[31:0]`. On `rsp_valid`&&`rsp_ready`, go to IDLE.
- No new grant occurs in the DONE cycle, even when `rsp_ready`=1.
- The multiplier enable is high only in P0–P3. In all other states its operands are driven to 0.
- Low-word result is identical for signed and unsigned ops.

## Timing
- Reset values: `req_ready`=00, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rr`=0, state IDLE, `acc`=0.
- Grant at cycle T. Passes occupy T+1…T+4, or T+1…T+3 for a FAST_LO low op. `rsp_valid` rises at T+5, or T+4 for FAST_LO low ops.
- The response holds stable under backpressure until accepted. Throughput is one op per latency + 1 cycle.
- `flush` is sampled every cycle and overrides everything:
  - forces IDLE and drops `rsp_valid` next cycle;
  - no grant in a flush cycle;
  - the aborted op produces no response;
  - `rr` is unchanged.
- Async reset mid-op aborts immediately with no response. Operation resumes from IDLE on the first edge after deassertion.
- Requester inputs are only sampled in the grant cycle. Later changes are ignored.

## Structure
- Shared package/defines: state encodings, `OP_HI`/`OP_SGN` bit positions, and `MUL_PASSES`=4.
- One natural sub-module, `mp_mul_pass`: combinational pass select plus sign-extend/shift of the partial into the 64-bit addend.
- The existing 16×16 Booth multiplier is instantiated once, outside that sub-module.

## Test plan
- Req0, a=0x00010000, b=0x00010000, op=HI unsigned → `rsp_data`=0x00000001, id=0, `rsp_valid` at T+5.
- Req1, a=b=0xFFFFFFFF, op=HI unsigned → 0xFFFFFFFE. Same operands with op=HI signed → 0x00000000. Low-word op → 0x00000001 at T+4 (FAST_LO=1).
- Signed a=0xFFFFFFFE (−2), b=3:
  - HI → 0xFFFFFFFF.
  - LO → 0xFFFFFFFA.
  - FAST_LO=0 build: LO latency is T+5.
- Both requesters continuously valid over 4 ops → grants in the order 0, 1, 0, 1, with `rsp_id` matching.
- Hold `rsp_ready`=0 for 7 cycles in DONE → data and id stable, no further grant. Accepted on the first ready cycle, next grant one cycle later.
- Assert `flush` during P2, then deassert `rst_n` during P1 of the next op → no response for either op, all outputs at reset values, next op completes normally.
